// File: rtl/entrada_numero_base_pkg.sv
`default_nettype none
// ============================================================================
// entrada_numero_base_pkg : base codes, radix lookup and FSM states for digit entry
// Rev 1.0
// ============================================================================
package entrada_numero_base_pkg;

  localparam logic [1:0] BASE_BIN = 2'b00;
  localparam logic [1:0] BASE_OCT = 2'b01;
  localparam logic [1:0] BASE_DEC = 2'b10;
  localparam logic [1:0] BASE_HEX = 2'b11;

  typedef enum logic [1:0] {
    VAZIO      = 2'd0,
    ACUMULANDO = 2'd1,
    ENVIANDO   = 2'd2,
    ERRO       = 2'd3
  } estado_t;

  function automatic logic [4:0] base_para_radix(input logic [1:0] base);
    logic [4:0] radix;
    case (base)
      BASE_BIN: radix = 5'd2;
      BASE_OCT: radix = 5'd8;
      BASE_DEC: radix = 5'd10;
      default:  radix = 5'd16;
    endcase
    return radix;
  endfunction

endpackage
`default_nettype wire

// File: rtl/entrada_numero_base_condicionador_tecla.sv
`default_nettype none
// ============================================================================
// condicionador_tecla : synchronizer + debounce + one-cycle press pulse for an active-low key
// Rev 1.0
// ============================================================================
module condicionador_tecla #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int SYNC_ESTAGIOS   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tecla_n,
  output logic o_evento
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

  logic [SYNC_ESTAGIOS-1:0] r_sync;
  logic                     r_estavel;
  logic                     r_estavel_ant;
  logic [CW-1:0]            r_cont;
  logic                     w_sincronizado;

  assign w_sincronizado = r_sync[SYNC_ESTAGIOS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync        <= '1;
      r_estavel     <= 1'b1;
      r_estavel_ant <= 1'b1;
      r_cont        <= '0;
    end else begin
      r_sync[0] <= i_tecla_n;
      for (int k = 1; k < SYNC_ESTAGIOS; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_estavel_ant <= r_estavel;
      // Any cycle where the synced level agrees with the stable one restarts the count
      if (w_sincronizado != r_estavel) begin
        if (r_cont == CW'(DEBOUNCE_CICLOS - 1)) begin
          r_estavel <= w_sincronizado;
          r_cont    <= '0;
        end else begin
          r_cont <= r_cont + 1'b1;
        end
      end else begin
        r_cont <= '0;
      end
    end
  end

  assign o_evento = r_estavel_ant & ~r_estavel;

endmodule
`default_nettype wire

// File: rtl/entrada_numero_base.sv
`default_nettype none
// ============================================================================
// entrada_numero_base : keyed digit entry in bin/oct/dec/hex, accumulated and offered over valid/ready
// Rev 1.0
// ============================================================================
module entrada_numero_base
  import entrada_numero_base_pkg::*;
#(
  parameter int LARGURA         = 8,
  parameter int MAX_DIGITOS     = 8,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int SYNC_ESTAGIOS   = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [1:0]         base_selecionada,
  input  logic [3:0]         digito,
  input  logic               tecla_digito_n,
  input  logic               tecla_enviar_n,
  input  logic               tecla_limpar_n,
  output logic [LARGURA-1:0] valor_parcial,
  output logic [3:0]         num_digitos,
  output logic [LARGURA-1:0] valor,
  output logic               valor_valido,
  input  logic               valor_pronto,
  output logic               erro_digito,
  output logic               erro_overflow,
  output logic               ocupado
);

  localparam int LN = LARGURA + 4;

  logic w_ev_digito;
  logic w_ev_enviar;
  logic w_ev_limpar;

  condicionador_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS), .SYNC_ESTAGIOS(SYNC_ESTAGIOS)) u_tecla_digito (
    .clk(CLOCK_50), .rst_n(reset_n), .i_tecla_n(tecla_digito_n), .o_evento(w_ev_digito)
  );
  condicionador_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS), .SYNC_ESTAGIOS(SYNC_ESTAGIOS)) u_tecla_enviar (
    .clk(CLOCK_50), .rst_n(reset_n), .i_tecla_n(tecla_enviar_n), .o_evento(w_ev_enviar)
  );
  condicionador_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS), .SYNC_ESTAGIOS(SYNC_ESTAGIOS)) u_tecla_limpar (
    .clk(CLOCK_50), .rst_n(reset_n), .i_tecla_n(tecla_limpar_n), .o_evento(w_ev_limpar)
  );

  estado_t            r_estado, w_estado;
  logic [LARGURA-1:0] r_acc, w_acc;
  logic [3:0]         r_num, w_num;
  logic [LARGURA-1:0] r_valor, w_valor;
  logic               r_valido, w_valido;
  logic               r_erro_dig, w_erro_dig;
  logic               r_erro_ovf, w_erro_ovf;

  logic [4:0]    w_radix;
  logic [LN-1:0] w_novo;
  logic          w_novo_excede;
  logic          w_digito_invalido;
  logic          w_cheio;

  assign w_radix           = base_para_radix(base_selecionada);
  assign w_novo            = LN'(r_acc) * LN'(w_radix) + LN'(digito);
  assign w_novo_excede     = |w_novo[LN-1:LARGURA];
  assign w_digito_invalido = ({1'b0, digito} >= w_radix);
  assign w_cheio           = (r_num == 4'(MAX_DIGITOS));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= VAZIO;
      r_acc      <= '0;
      r_num      <= '0;
      r_valor    <= '0;
      r_valido   <= 1'b0;
      r_erro_dig <= 1'b0;
      r_erro_ovf <= 1'b0;
    end else begin
      r_estado   <= w_estado;
      r_acc      <= w_acc;
      r_num      <= w_num;
      r_valor    <= w_valor;
      r_valido   <= w_valido;
      r_erro_dig <= w_erro_dig;
      r_erro_ovf <= w_erro_ovf;
    end
  end

  always_comb begin
    w_estado   = r_estado;
    w_acc      = r_acc;
    w_num      = r_num;
    w_valor    = r_valor;
    w_valido   = r_valido;
    w_erro_dig = r_erro_dig;
    w_erro_ovf = r_erro_ovf;
    case (r_estado)
      // Keys are ignored here so valid can only fall through an accepted handshake
      ENVIANDO: begin
        if (valor_pronto) begin
          w_valido = 1'b0;
          w_acc    = '0;
          w_num    = '0;
          w_estado = VAZIO;
        end
      end
      ERRO: begin
        if (w_ev_limpar) begin
          w_acc      = '0;
          w_num      = '0;
          w_erro_dig = 1'b0;
          w_erro_ovf = 1'b0;
          w_estado   = VAZIO;
        end
      end
      default: begin
        if (w_ev_limpar) begin
          w_acc      = '0;
          w_num      = '0;
          w_erro_dig = 1'b0;
          w_erro_ovf = 1'b0;
          w_estado   = VAZIO;
        end else if (w_ev_enviar) begin
          if (r_estado == ACUMULANDO) begin
            w_valor  = r_acc;
            w_valido = 1'b1;
            w_estado = ENVIANDO;
          end
        end else if (w_ev_digito) begin
          if (w_digito_invalido) begin
            w_erro_dig = 1'b1;
            w_estado   = ERRO;
          end else if (w_cheio || w_novo_excede) begin
            w_erro_ovf = 1'b1;
            w_estado   = ERRO;
          end else begin
            w_acc    = w_novo[LARGURA-1:0];
            w_num    = r_num + 4'd1;
            w_estado = ACUMULANDO;
          end
        end
      end
    endcase
  end

  assign valor_parcial = r_acc;
  assign num_digitos   = r_num;
  assign valor         = r_valor;
  assign valor_valido  = r_valido;
  assign erro_digito   = r_erro_dig;
  assign erro_overflow = r_erro_ovf;
  assign ocupado       = (r_estado != VAZIO);

endmodule
`default_nettype wire

// File: tb/tb_entrada_numero_base.sv
`default_nettype none
// ============================================================================
// tb_entrada_numero_base : scoreboard bench with directed scenarios and randomized key sequences
// Rev 1.0
// ============================================================================
module tb_entrada_numero_base;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] base;
  logic [3:0] dig;
  logic       kd_n, ke_n, kl_n;
  logic [7:0] parcial, valor;
  logic [3:0] ndig;
  logic       valido, pronto, ed, eo, ocup;

  int n_vec = 0;
  int n_err = 0;
  int q[$];
  int m_acc, m_nd;
  bit m_ed, m_eo;
  int pronto_mode;
  int valid_cnt;

  always #5 clk = ~clk;

  entrada_numero_base #(.LARGURA(8), .MAX_DIGITOS(8), .DEBOUNCE_CICLOS(4), .SYNC_ESTAGIOS(2)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .base_selecionada(base), .digito(dig),
    .tecla_digito_n(kd_n), .tecla_enviar_n(ke_n), .tecla_limpar_n(kl_n),
    .valor_parcial(parcial), .num_digitos(ndig), .valor(valor), .valor_valido(valido),
    .valor_pronto(pronto), .erro_digito(ed), .erro_overflow(eo), .ocupado(ocup)
  );

  task automatic chk(input string nome, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
    end
  endtask

  // Consumer ready: 0 random, 1 held low, 2 held high; changes away from the sampling edge
  always begin
    @(posedge clk);
    #2;
    case (pronto_mode)
      1:       pronto = 1'b0;
      2:       pronto = 1'b1;
      default: pronto = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Monitor: a handshake occurs on the edge following a negedge that sees valid && ready
  always @(negedge clk) begin
    if (rst_n && valido && pronto) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL handshake: offered value %0d, expected no offer", valor);
      end else begin
        chk("valor", int'(valor), q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int radix_of(input logic [1:0] b);
    case (b)
      2'b00:   return 2;
      2'b01:   return 8;
      2'b10:   return 10;
      default: return 16;
    endcase
  endfunction

  function automatic void model_digit(input logic [1:0] b, input int d);
    int r;
    r = radix_of(b);
    if (m_ed || m_eo) return;
    if (d >= r) m_ed = 1;
    else if (m_nd == 8) m_eo = 1;
    else if (m_acc * r + d > 255) m_eo = 1;
    else begin
      m_acc = m_acc * r + d;
      m_nd++;
    end
  endfunction

  function automatic void model_clear();
    m_acc = 0; m_nd = 0; m_ed = 0; m_eo = 0;
  endfunction

  task automatic press(input int k);
    valid_cnt = 0;
    case (k)
      0:       kd_n = 1'b0;
      1:       ke_n = 1'b0;
      default: kl_n = 1'b0;
    endcase
    repeat (10) begin
      @(negedge clk);
      if (valido) valid_cnt++;
    end
    kd_n = 1'b1; ke_n = 1'b1; kl_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (valido) valid_cnt++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " valor_parcial"}, int'(parcial), m_acc);
    chk({tag, " num_digitos"},   int'(ndig), m_nd);
    chk({tag, " erro_digito"},   int'(ed), int'(m_ed));
    chk({tag, " erro_overflow"}, int'(eo), int'(m_eo));
    chk({tag, " ocupado"},       int'(ocup), int'(m_ed || m_eo || m_nd > 0));
  endtask

  task automatic do_digit(input logic [1:0] b, input int d);
    base = b;
    dig  = 4'(d);
    press(0);
    model_digit(b, d);
    check_state("digit");
  endtask

  task automatic do_limpar();
    press(2);
    model_clear();
    check_state("limpar");
  endtask

  task automatic do_enviar();
    bit sends;
    int t;
    sends = !(m_ed || m_eo) && (m_nd > 0);
    if (sends) q.push_back(m_acc);
    press(1);
    if (sends) begin
      t = 0;
      while (valido && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) chk("valid release timeout", int'(valido), 0);
      m_acc = 0;
      m_nd  = 0;
    end else begin
      chk("enviar ignored valid", int'(valido), 0);
    end
    check_state("enviar");
  endtask

  initial begin
    rst_n = 1'b0; kd_n = 1'b1; ke_n = 1'b1; kl_n = 1'b1;
    base = 2'b10; dig = 4'd0; pronto_mode = 0; pronto = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset valor_parcial", int'(parcial), 0);
    chk("reset valor", int'(valor), 0);
    chk("reset valor_valido", int'(valido), 0);
    chk("reset ocupado", int'(ocup), 0);
    chk("reset erros", int'({ed, eo}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: decimal 255 with consumer ready -> valid lasts exactly one cycle
    pronto_mode = 2;
    do_digit(2'b10, 2); do_digit(2'b10, 5); do_digit(2'b10, 5);
    chk("t1 num_digitos before send", int'(ndig), 3);
    do_enviar();
    chk("t1 valid cycles", valid_cnt, 1);

    // 2: decimal overflow, enviar ignored, limpar clears
    pronto_mode = 0;
    do_digit(2'b10, 2); do_digit(2'b10, 5); do_digit(2'b10, 6);
    chk("t2 parcial after overflow", int'(parcial), 8'h19);
    do_enviar();
    do_limpar();

    // 3: invalid octal digit, later digits ignored
    do_digit(2'b01, 4'hA);
    do_digit(2'b01, 3);
    do_digit(2'b11, 5);
    do_limpar();

    // 4: hex FF held while consumer stalls; limpar ignored during the offer
    pronto_mode = 1;
    do_digit(2'b11, 15); do_digit(2'b11, 15);
    q.push_back(255);
    press(1);
    repeat (10) @(negedge clk);
    chk("t4 valid held", int'(valido), 1);
    chk("t4 valor held", int'(valor), 255);
    press(2);
    chk("t4 valid after limpar", int'(valido), 1);
    chk("t4 parcial after limpar", int'(parcial), 255);
    pronto_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("t4 valid drop", int'(valido), 0);
    m_acc = 0; m_nd = 0;
    check_state("t4 end");

    // 5: base change mid-entry and glitch rejection
    pronto_mode = 0;
    do_digit(2'b00, 1); do_digit(2'b00, 0);
    do_digit(2'b11, 3);
    chk("t5 mixed base", int'(parcial), 8'h23);
    dig = 4'd7;
    kd_n = 1'b0;
    repeat (3) @(negedge clk);
    kd_n = 1'b1;
    repeat (12) @(negedge clk);
    check_state("t5 glitch");
    do_enviar();

    // 6: asynchronous reset during an offer
    pronto_mode = 1;
    do_digit(2'b10, 7);
    q.push_back(7);
    press(1);
    chk("t6 offering", int'(valido), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 reset valid", int'(valido), 0);
    chk("t6 reset valor", int'(valor), 0);
    chk("t6 reset parcial", int'(parcial), 0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    pronto_mode = 0;
    @(negedge clk);
    do_digit(2'b10, 4);

    // Randomized key sequences
    for (int i = 0; i < 200; i++) begin
      int r;
      int d;
      logic [1:0] b;
      r = $urandom_range(0, 99);
      b = base;
      if ($urandom_range(0, 3) == 0) b = 2'($urandom_range(0, 3));
      if (r < 65) begin
        if ($urandom_range(0, 9) < 8) d = $urandom_range(0, radix_of(b) - 1);
        else d = $urandom_range(0, 15);
        do_digit(b, d);
      end else if (r < 82) begin
        do_enviar();
      end else begin
        do_limpar();
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
